// File: rtl/datapath_sequencer.sv
// Moore sequencer that drives every control line of the 5-bit two-AU datapath for one
// load / accumulate / split / fold job, ending with a one-cycle done pulse.
module datapath_sequencer #(
    parameter logic [1:0] OP_ADD = 2'b00,
    parameter logic [1:0] OP_SUB = 2'b01,
    parameter int         ITER_W = 3
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [ITER_W-1:0] iter,
    output logic              busy,
    output logic              R1_e,
    output logic              R2_e,
    output logic              R3_e,
    output logic              R4_e,
    output logic              R5_e,
    output logic              R1_tri,
    output logic              R2_tri,
    output logic              In1_tri,
    output logic              In2_tri,
    output logic              AU1_tri,
    output logic              AU1_tri1,
    output logic              shift3_tri,
    output logic              AU2_tri,
    output logic              R4_tri,
    output logic              R5_tri,
    output logic [1:0]        AU1_op,
    output logic [1:0]        AU2_op,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACC,
        S_SPLIT,
        S_MIX4,
        S_MIX5,
        S_DONE
    } state_t;

    typedef struct packed {
        logic       busy;
        logic       r1_e;
        logic       r2_e;
        logic       r3_e;
        logic       r4_e;
        logic       r5_e;
        logic       r1_tri;
        logic       r2_tri;
        logic       in1_tri;
        logic       in2_tri;
        logic       au1_tri;
        logic       au1_tri1;
        logic       shift3_tri;
        logic       au2_tri;
        logic       r4_tri;
        logic       r5_tri;
        logic [1:0] au1_op;
        logic [1:0] au2_op;
        logic       done;
    } ctrl_t;

    // Control word for a state; each state drives at most one source per shared bus.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c        = '0;
        c.au1_op = OP_ADD;
        c.au2_op = OP_ADD;
        case (s)
            S_LOAD: begin
                c.busy    = 1'b1;
                c.in2_tri = 1'b1;
                c.r1_e    = 1'b1;
                c.in1_tri = 1'b1;
                c.r2_e    = 1'b1;
            end
            S_ACC: begin
                c.busy    = 1'b1;
                c.r2_tri  = 1'b1;
                c.au1_op  = OP_ADD;
                c.au1_tri = 1'b1;
                c.r1_e    = 1'b1;
            end
            S_SPLIT: begin
                c.busy       = 1'b1;
                c.r2_tri     = 1'b1;
                c.au1_op     = OP_ADD;
                c.r4_e       = 1'b1;
                c.r5_e       = 1'b1;
                c.shift3_tri = 1'b1;
                c.r3_e       = 1'b1;
            end
            S_MIX4: begin
                c.busy    = 1'b1;
                c.r4_tri  = 1'b1;
                c.au2_op  = OP_SUB;
                c.au2_tri = 1'b1;
                c.r3_e    = 1'b1;
            end
            S_MIX5: begin
                c.busy    = 1'b1;
                c.r5_tri  = 1'b1;
                c.au2_op  = OP_ADD;
                c.au2_tri = 1'b1;
                c.r3_e    = 1'b1;
            end
            S_DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: c = c;
        endcase
        return c;
    endfunction

    state_t            state;
    logic [ITER_W-1:0] cnt;
    ctrl_t             ctrl;

    // Outputs are registered alongside the state so each is a pure decode of the next state.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_IDLE;
            cnt   <= '0;
            ctrl  <= decode(S_IDLE);
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= iter;
                        state <= S_LOAD;
                        ctrl  <= decode(S_LOAD);
                    end
                end
                S_LOAD: begin
                    if (cnt != '0) begin
                        state <= S_ACC;
                        ctrl  <= decode(S_ACC);
                    end else begin
                        state <= S_SPLIT;
                        ctrl  <= decode(S_SPLIT);
                    end
                end
                S_ACC: begin
                    cnt <= cnt - ITER_W'(1);
                    if (cnt > ITER_W'(1)) begin
                        state <= S_ACC;
                        ctrl  <= decode(S_ACC);
                    end else begin
                        state <= S_SPLIT;
                        ctrl  <= decode(S_SPLIT);
                    end
                end
                S_SPLIT: begin
                    state <= S_MIX4;
                    ctrl  <= decode(S_MIX4);
                end
                S_MIX4: begin
                    state <= S_MIX5;
                    ctrl  <= decode(S_MIX5);
                end
                S_MIX5: begin
                    state <= S_DONE;
                    ctrl  <= decode(S_DONE);
                end
                default: begin
                    state <= S_IDLE;
                    ctrl  <= decode(S_IDLE);
                end
            endcase
        end
    end

    assign busy       = ctrl.busy;
    assign R1_e       = ctrl.r1_e;
    assign R2_e       = ctrl.r2_e;
    assign R3_e       = ctrl.r3_e;
    assign R4_e       = ctrl.r4_e;
    assign R5_e       = ctrl.r5_e;
    assign R1_tri     = ctrl.r1_tri;
    assign R2_tri     = ctrl.r2_tri;
    assign In1_tri    = ctrl.in1_tri;
    assign In2_tri    = ctrl.in2_tri;
    assign AU1_tri    = ctrl.au1_tri;
    assign AU1_tri1   = ctrl.au1_tri1;
    assign shift3_tri = ctrl.shift3_tri;
    assign AU2_tri    = ctrl.au2_tri;
    assign R4_tri     = ctrl.r4_tri;
    assign R5_tri     = ctrl.r5_tri;
    assign AU1_op     = ctrl.au1_op;
    assign AU2_op     = ctrl.au2_op;
    assign done       = ctrl.done;

endmodule
